main_function_a_loader: RTL and testbench

Input-side ping-pong loader that sits directly upstream of the `main_function` dataflow top. It accepts a stream of 32-bit words with a valid/ready handshake and packs each group of `DEPTH` words into one of two frame banks. It serves the full bank to `main_function` through the `A_address0/A_ce0/A_q0` read port and drives `ap_start` until `main_function` signals `ap_ready`. Loading of the next frame overlaps processing of the current one.

---
 rtl/main_function_a_loader_if.sv | 25 ++
 rtl/main_function_a_loader.sv | 112 +++++++++++
 tb/tb_main_function_a_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/main_function_a_loader_if.sv
// Stream-in, BRAM-style read port and ap_start/ap_ready bundle for the A loader.
// master: upstream source plus main_function read side; slave: the loader itself.
interface main_function_a_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] A_address0;
  logic                  A_ce0;
  logic [DATA_WIDTH-1:0] A_q0;
  logic                  ap_start;
  logic                  ap_ready;

  modport master (
    output s_data, s_valid, A_address0, A_ce0, ap_ready,
    input  s_ready, A_q0, ap_start
  );

  modport slave (
    input  s_data, s_valid, A_address0, A_ce0, ap_ready,
    output s_ready, A_q0, ap_start
  );
endinterface

// File: rtl/main_function_a_loader.sv
// Ping-pong frame loader: packs DEPTH stream words per bank and serves the full bank to main_function.
// Latency: ap_start the cycle after the last word of a frame; A_q0 one cycle after A_ce0.
// Backpressure: s_ready drops only while both banks hold unreleased frames.
// Optional frames_loaded counter: define MAIN_FUNCTION_A_LOADER_STATS_EN.
module main_function_a_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 5,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
  output logic [15:0]             frames_loaded,
`endif
  main_function_a_loader_if.slave bus
);

  // Frame storage; contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [0:1][0:DEPTH-1];

  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q,    full_d;
  logic [DATA_WIDTH-1:0] a_q0_q;

  logic                  wr_fire;
  logic                  wr_last;
  logic                  rel_fire;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  // Both handshake outputs come straight from the flag register so reset clears them at once.
  assign bus.s_ready  = ~full_q[wr_bank_q];
  assign bus.ap_start = full_q[rd_bank_q];
  assign bus.A_q0     = a_q0_q;

  assign wr_fire  = bus.s_valid & ~full_q[wr_bank_q];
  assign wr_last  = (wr_addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign rel_fire = full_q[rd_bank_q] & bus.ap_ready;
  assign addr_ok  = (32'(bus.A_address0) < 32'(DEPTH));
  assign rd_word  = addr_ok ? mem_q[rd_bank_q][bus.A_address0] : '0;

  // Next-state for the bank pointers and full flags; fill and release may land together.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (wr_fire) begin
      if (wr_last) begin
        wr_addr_d         = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end
    end
    // A release always targets the other flag than a same-cycle fill, so no ordering hazard.
    if (rel_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control state; reset discards any partial or pending frame.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // Accepted words land in the current write bank.
  always_ff @(posedge ap_clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_addr_q] <= bus.s_data;
    end
  end

  // Registered read port; holds when A_ce0 is low, out-of-range addresses read as zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_q0_q <= '0;
    end else if (bus.A_ce0) begin
      a_q0_q <= rd_word;
    end
  end

`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
  logic [15:0] frames_q;

  // Count completed bank fills, wrapping naturally at 16 bits.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frames_q <= '0;
    end else if (wr_fire && wr_last) begin
      frames_q <= frames_q + 16'd1;
    end
  end

  assign frames_loaded = frames_q;
`endif

endmodule

// File: tb/tb_main_function_a_loader.sv
// Bench for main_function_a_loader: directed table, reset corner cases, random traffic vs a frame-queue model.
module tb_main_function_a_loader;
  localparam int DW    = 32;
  localparam int DEPTH = 5;
  localparam int AW    = 3;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  main_function_a_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
  logic [15:0] frames_loaded;
`endif

  main_function_a_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
    .frames_loaded(frames_loaded),
`endif
    .bus          (bus)
  );

  // Reference model: completed frames waiting for main_function, oldest first, plus the partial frame.
  typedef logic [DW-1:0] frame_t [DEPTH];
  frame_t        fq[$];
  logic [DW-1:0] part[$];
  logic [DW-1:0] mq;
  bit            mq_known;
  int unsigned   m_frames;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          ce;
    logic [2:0]  a;
    bit          rdy;
    bit          e_sr;
    bit          e_st;
    bit          cq;
    logic [31:0] e_q;
  } vec_t;
  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    fq.delete();
    part.delete();
    mq       = '0;
    mq_known = 1'b1;
    m_frames = 0;
  endtask

  // One clock: drive at posedge+1, check handshake at posedge+4, check A_q0 at next posedge+1.
  task automatic cycle(input bit v, input logic [31:0] d, input bit ce, input logic [AW-1:0] a,
                       input bit rdy, output bit sr, output bit st, output logic [31:0] q);
    bit     m_sr, m_st, fire, rel;
    frame_t f;
    bus.s_valid    = v;
    bus.s_data     = d;
    bus.A_ce0      = ce;
    bus.A_address0 = a;
    bus.ap_ready   = rdy;
    #3;
    m_sr = (fq.size() < 2);
    m_st = (fq.size() > 0);
    sr   = bus.s_ready;
    st   = bus.ap_start;
    chk("s_ready", 32'(sr), 32'(m_sr));
    chk("ap_start", 32'(st), 32'(m_st));
    fire = v && m_sr;
    rel  = m_st && rdy;
    if (ce) begin
      if (int'(a) >= DEPTH) begin
        mq = '0; mq_known = 1'b1;
      end else if (m_st) begin
        mq = fq[0][a]; mq_known = 1'b1;
      end else begin
        mq_known = 1'b0;
      end
    end
    if (rel) void'(fq.pop_front());
    if (fire) begin
      part.push_back(d);
      if (part.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) f[i] = part[i];
        fq.push_back(f);
        part.delete();
        m_frames++;
      end
    end
    @(posedge ap_clk);
    #1;
    q = bus.A_q0;
    if (mq_known) chk("A_q0", q, mq);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          sr, st;
    logic [31:0] q;

    // Directed table: frame 1..5, frame 6..10 while held, range reads, hold, release.
    vt[0]  = '{1'b1, 32'd1,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b1, 32'd2,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vt[2]  = '{1'b1, 32'd3,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vt[3]  = '{1'b1, 32'd4,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vt[4]  = '{1'b1, 32'd5,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vt[5]  = '{1'b1, 32'd6,  1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1};
    vt[6]  = '{1'b1, 32'd7,  1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2};
    vt[7]  = '{1'b1, 32'd8,  1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3};
    vt[8]  = '{1'b1, 32'd9,  1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4};
    vt[9]  = '{1'b1, 32'd10, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5};
    vt[10] = '{1'b1, 32'd11, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
    vt[11] = '{1'b1, 32'd11, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
    vt[12] = '{1'b1, 32'd11, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
    vt[13] = '{1'b1, 32'd11, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4};
    vt[14] = '{1'b1, 32'd11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4};
    vt[15] = '{1'b1, 32'd11, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4};
    vt[16] = '{1'b1, 32'd11, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd6};
    vt[17] = '{1'b0, 32'd0,  1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'd10};

    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.A_ce0      = 1'b0;
    bus.A_address0 = '0;
    bus.ap_ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_ap_start", 32'(bus.ap_start), 32'd0);
    chk("rst_A_q0", bus.A_q0, 32'd0);
`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
    chk("rst_frames", 32'(frames_loaded), 32'd0);
`endif
    ap_rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].v, vt[i].d, vt[i].ce, vt[i].a, vt[i].rdy, sr, st, q);
      chk($sformatf("vec%0d_s_ready", i), 32'(sr), 32'(vt[i].e_sr));
      chk($sformatf("vec%0d_ap_start", i), 32'(st), 32'(vt[i].e_st));
      if (vt[i].cq) chk($sformatf("vec%0d_A_q0", i), q, vt[i].e_q);
    end

    // Reset while a frame is pending and a partial frame is in progress.
    ap_rst_n = 1'b0;
    model_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 32'(50 + i), 1'b0, '0, 1'b0, sr, st, q);
    chk("pre_rst_ap_start", 32'(bus.ap_start), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("async_rst_ap_start", 32'(bus.ap_start), 32'd0);
    chk("async_rst_A_q0", bus.A_q0, 32'd0);
    model_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // Gappy valid: only accepted words count toward the frame.
    for (int i = 0; i < 2 * DEPTH; i++) cycle(i % 2 == 0, 32'(100 + i), 1'b0, '0, 1'b0, sr, st, q);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, sr, st, q);
    chk("gappy_ap_start", 32'(st), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, AW'(i), 1'b0, sr, st, q);
      chk($sformatf("gappy_rd%0d", i), q, 32'(100 + 2 * i));
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, sr, st, q);
    end
`ifdef MAIN_FUNCTION_A_LOADER_STATS_EN
    chk("frames_loaded", 32'(frames_loaded), 32'(m_frames[15:0]));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
